// File: rtl/mesh_wormhole_packetizer.sv
`default_nettype none
// ============================================================================
// Module  : mesh_wormhole_packetizer
// Brief   : Serialises one packet per handshake into HEAD/BODY/TAIL wormhole
//           flits for a mesh node TERM input; rejects out-of-mesh destinations.
// Revision: 1.0
// ============================================================================
module mesh_wormhole_packetizer #(
  parameter int ROW_N       = 3,
  parameter int COL_M       = 3,
  parameter int CHANNEL_W   = 8,
  parameter int FLIT_ID_W   = 2,
  parameter int MAX_PAYLOAD = 4,
  localparam int FLIT_DATA_W = CHANNEL_W - FLIT_ID_W,
  localparam int ROW_ADDR_W  = (ROW_N > 1) ? $clog2(ROW_N) : 1,
  localparam int COL_ADDR_W  = (COL_M > 1) ? $clog2(COL_M) : 1,
  localparam int LEN_W       = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [ROW_ADDR_W-1:0]              pkt_dst_row_i,
  input  logic [COL_ADDR_W-1:0]              pkt_dst_col_i,
  input  logic [LEN_W-1:0]                   pkt_len_i,
  input  logic [MAX_PAYLOAD*FLIT_DATA_W-1:0] pkt_data_i,
  input  logic                               pkt_vld_i,
  output logic                               pkt_rdy_o,
  output logic [CHANNEL_W-1:0]               flit_data_o,
  output logic                               flit_vld_o,
  input  logic                               flit_rdy_i,
  output logic                               err_o,
  output logic                               pkt_sent_o
);

  if (ROW_ADDR_W + COL_ADDR_W > FLIT_DATA_W) begin : g_addr_width_check
    $error("mesh_wormhole_packetizer: destination does not fit in HEAD flit data");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEAD    = 2'd1,
    S_PAYLOAD = 2'd2
  } state_t;

  localparam logic [FLIT_ID_W-1:0]  c_ID_HEAD = 2'b01;
  localparam logic [FLIT_ID_W-1:0]  c_ID_BODY = 2'b10;
  localparam logic [FLIT_ID_W-1:0]  c_ID_TAIL = 2'b11;
  localparam logic [ROW_ADDR_W:0]   c_ROW_LIM = (ROW_ADDR_W + 1)'(ROW_N);
  localparam logic [COL_ADDR_W:0]   c_COL_LIM = (COL_ADDR_W + 1)'(COL_M);
  localparam logic [LEN_W-1:0]      c_MAX_LEN = LEN_W'(MAX_PAYLOAD);

  state_t                             r_state;
  logic [LEN_W-1:0]                   r_len;
  logic [LEN_W-1:0]                   r_idx;
  logic [MAX_PAYLOAD*FLIT_DATA_W-1:0] r_payload;
  logic [CHANNEL_W-1:0]               r_flit_data;
  logic                               r_flit_vld;
  logic                               r_err;
  logic                               r_sent;

  logic [FLIT_ID_W-1:0]   w_cur_id;
  logic                   w_xfer;
  logic                   w_tail_xfer;
  logic                   w_accept;
  logic                   w_dst_ok;
  logic [LEN_W-1:0]       w_len;
  logic [LEN_W-1:0]       w_next_idx;
  logic [FLIT_DATA_W-1:0] w_word;
  logic                   w_next_last;
  logic [CHANNEL_W-1:0]   w_head_flit;
  logic [CHANNEL_W-1:0]   w_payload_flit;

  assign w_cur_id    = r_flit_data[CHANNEL_W-1 -: FLIT_ID_W];
  assign w_xfer      = r_flit_vld & flit_rdy_i;
  assign w_tail_xfer = w_xfer & (w_cur_id == c_ID_TAIL);

  // Ready also opens on the TAIL transfer cycle so packets can follow with no bubble.
  assign pkt_rdy_o = ~rst_i & ((r_state == S_IDLE) | w_tail_xfer);
  assign w_accept  = pkt_vld_i & pkt_rdy_o;

  assign w_dst_ok = ({1'b0, pkt_dst_row_i} < c_ROW_LIM) &
                    ({1'b0, pkt_dst_col_i} < c_COL_LIM);

  always_comb begin
    w_len = pkt_len_i;
    if (pkt_len_i == '0) begin
      w_len = LEN_W'(1);
    end else if (pkt_len_i > c_MAX_LEN) begin
      w_len = c_MAX_LEN;
    end
  end

  assign w_head_flit = {c_ID_HEAD, FLIT_DATA_W'({pkt_dst_row_i, pkt_dst_col_i})};

  // r_idx tracks the payload flit on the output; HEAD hands over to word 0.
  assign w_next_idx = (r_state == S_HEAD) ? r_idx : r_idx + LEN_W'(1);

  always_comb begin
    w_word = '0;
    for (int k = 0; k < MAX_PAYLOAD; k++) begin
      if (w_next_idx == LEN_W'(k)) begin
        w_word = r_payload[k*FLIT_DATA_W +: FLIT_DATA_W];
      end
    end
  end

  assign w_next_last    = (w_next_idx == r_len - LEN_W'(1));
  assign w_payload_flit = {(w_next_last ? c_ID_TAIL : c_ID_BODY), w_word};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_idx       <= '0;
      r_payload   <= '0;
      r_flit_data <= '0;
      r_flit_vld  <= 1'b0;
      r_err       <= 1'b0;
      r_sent      <= 1'b0;
    end else begin
      r_err  <= 1'b0;
      r_sent <= w_tail_xfer;
      if (w_accept) begin
        r_idx <= '0;
        if (w_dst_ok) begin
          r_len       <= w_len;
          r_payload   <= pkt_data_i;
          r_flit_data <= w_head_flit;
          r_flit_vld  <= 1'b1;
          r_state     <= S_HEAD;
        end else begin
          r_err       <= 1'b1;
          r_flit_data <= '0;
          r_flit_vld  <= 1'b0;
          r_state     <= S_IDLE;
        end
      end else if (w_tail_xfer) begin
        r_flit_data <= '0;
        r_flit_vld  <= 1'b0;
        r_state     <= S_IDLE;
      end else if (w_xfer) begin
        r_flit_data <= w_payload_flit;
        r_idx       <= w_next_idx;
        r_state     <= S_PAYLOAD;
      end
    end
  end

  assign flit_data_o = r_flit_data;
  assign flit_vld_o  = r_flit_vld;
  assign err_o       = r_err;
  assign pkt_sent_o  = r_sent;

endmodule
`default_nettype wire

// File: tb/tb_mesh_wormhole_packetizer.sv
`default_nettype none
// ============================================================================
// Module  : tb_mesh_wormhole_packetizer
// Brief   : Directed scoreboard bench for mesh_wormhole_packetizer.
// Revision: 1.0
// ============================================================================
module tb_mesh_wormhole_packetizer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pkt_dst_row;
  logic [1:0]  pkt_dst_col;
  logic [2:0]  pkt_len;
  logic [23:0] pkt_data;
  logic        pkt_vld;
  logic        pkt_rdy;
  logic [7:0]  flit_data;
  logic        flit_vld;
  logic        flit_rdy;
  logic        err;
  logic        pkt_sent;

  always #5 clk = ~clk;

  mesh_wormhole_packetizer dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pkt_dst_row_i(pkt_dst_row),
    .pkt_dst_col_i(pkt_dst_col),
    .pkt_len_i    (pkt_len),
    .pkt_data_i   (pkt_data),
    .pkt_vld_i    (pkt_vld),
    .pkt_rdy_o    (pkt_rdy),
    .flit_data_o  (flit_data),
    .flit_vld_o   (flit_vld),
    .flit_rdy_i   (flit_rdy),
    .err_o        (err),
    .pkt_sent_o   (pkt_sent)
  );

  int         n_vec  = 0;
  int         n_fail = 0;
  int         cyc    = 0;
  int         err_due = -10;
  int         acc_cyc = 0;
  int         last_head_cyc = 0;
  int         last_tail_cyc = -100;
  int         last_gap = 0;
  bit         exp_sent = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every flit transfer and checks side outputs.
  always @(negedge clk) begin
    if (rst) begin
      exp_sent   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("pkt_sent_o", {31'b0, pkt_sent}, {31'b0, exp_sent});
      check("err_o", {31'b0, err}, {31'b0, (cyc == err_due)});
      check("pkt_rdy_o", {31'b0, pkt_rdy},
            {31'b0, (!flit_vld || (flit_data[7:6] == 2'b11 && flit_rdy))});
      if (prev_stall) begin
        check("stall_vld", {31'b0, flit_vld}, 32'd1);
        check("stall_data", {24'b0, flit_data}, {24'b0, prev_data});
      end
      if (flit_vld && flit_rdy) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_flit: got %0h, want none (cycle %0d)", flit_data, cyc);
        end else begin
          check("flit", {24'b0, flit_data}, {24'b0, exp_q.pop_front()});
        end
        if (flit_data[7:6] == 2'b01) begin
          last_gap      = cyc - last_tail_cyc;
          last_head_cyc = cyc;
        end
        if (flit_data[7:6] == 2'b11) last_tail_cyc = cyc;
      end
      exp_sent   = flit_vld && flit_rdy && (flit_data[7:6] == 2'b11);
      prev_stall = flit_vld && !flit_rdy;
      prev_data  = flit_data;
    end
  end

  // n_exp == 0 means the destination is invalid and an err_o pulse is expected.
  task automatic send_pkt(input logic [1:0] row, input logic [1:0] col, input logic [2:0] len,
                          input logic [23:0] data, input int n_exp, input logic [63:0] exp_flits);
    int t;
    t = 0;
    pkt_dst_row = row;
    pkt_dst_col = col;
    pkt_len     = len;
    pkt_data    = data;
    pkt_vld     = 1'b1;
    @(negedge clk);
    while (!pkt_rdy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!pkt_rdy) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: got pkt_rdy_o=0, want 1 within 200 cycles");
      pkt_vld = 1'b0;
      return;
    end
    acc_cyc = cyc;
    if (n_exp == 0) err_due = cyc + 1;
    for (int i = 0; i < n_exp; i++) exp_q.push_back(exp_flits[i*8 +: 8]);
    @(posedge clk);
    #1;
    pkt_vld     = 1'b0;
    pkt_dst_row = 2'b11;
    pkt_dst_col = 2'b11;
    pkt_len     = 3'd5;
    pkt_data    = 24'hA5C3E7;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || flit_vld) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_done", {31'b0, (exp_q.size() == 0 && !flit_vld)}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b1;
    pkt_dst_row = '0;
    pkt_dst_col = '0;
    pkt_len     = '0;
    pkt_data    = '0;
    pkt_vld     = 1'b0;
    flit_rdy    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_flit_vld", {31'b0, flit_vld}, 32'd0);
    check("rst_flit_data", {24'b0, flit_data}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_sent", {31'b0, pkt_sent}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", {31'b0, pkt_rdy}, 32'd1);
    @(posedge clk);
    #1;

    // Basic dst(1,2) len 2 with latency check.
    send_pkt(2'd1, 2'd2, 3'd2, {6'h00, 6'h00, 6'h2A, 6'h15}, 3, {40'h0, 8'hEA, 8'h95, 8'h46});
    wait_drain();
    check("head_latency", last_head_cyc, acc_cyc + 1);

    // Same packet under a stalling sink: rdy 1,0,0,1,0,1.
    begin
      logic [5:0] pat;
      pat = 6'b101001;
      flit_rdy = pat[0];
      send_pkt(2'd1, 2'd2, 3'd2, {6'h00, 6'h00, 6'h2A, 6'h15}, 3, {40'h0, 8'hEA, 8'h95, 8'h46});
      for (int i = 1; i < 6; i++) begin
        @(posedge clk);
        #1;
        flit_rdy = pat[i];
      end
      flit_rdy = 1'b1;
      wait_drain();
    end

    // Back-to-back packets: second HEAD must follow first TAIL directly.
    send_pkt(2'd1, 2'd2, 3'd2, {6'h00, 6'h00, 6'h2A, 6'h15}, 3, {40'h0, 8'hEA, 8'h95, 8'h46});
    send_pkt(2'd2, 2'd0, 3'd1, {6'h00, 6'h00, 6'h00, 6'h01}, 2, {48'h0, 8'hC1, 8'h48});
    wait_drain();
    check("b2b_gap", last_gap, 1);

    // Out-of-range destinations, len 0 and len clamp.
    send_pkt(2'd3, 2'd0, 3'd1, {6'h00, 6'h00, 6'h00, 6'h11}, 0, 64'h0);
    wait_drain();
    send_pkt(2'd0, 2'd3, 3'd2, {6'h00, 6'h00, 6'h22, 6'h11}, 0, 64'h0);
    wait_drain();
    send_pkt(2'd0, 2'd0, 3'd0, {6'h00, 6'h00, 6'h00, 6'h3F}, 2, {48'h0, 8'hFF, 8'h40});
    wait_drain();
    send_pkt(2'd0, 2'd1, 3'd7, {6'h04, 6'h03, 6'h02, 6'h01}, 5,
             {24'h0, 8'hC4, 8'h83, 8'h82, 8'h81, 8'h41});
    wait_drain();

    // Reset while the second BODY flit is on the output.
    send_pkt(2'd2, 2'd2, 3'd3, {6'h00, 6'h0C, 6'h0B, 6'h0A}, 4, {32'h0, 8'hCC, 8'h8B, 8'h8A, 8'h4A});
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("pre_rst_body2", {24'b0, flit_data}, 32'h8B);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    check("midrst_flit_vld", {31'b0, flit_vld}, 32'd0);
    check("midrst_flit_data", {24'b0, flit_data}, 32'd0);
    check("midrst_sent", {31'b0, pkt_sent}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rdy_after_midrst", {31'b0, pkt_rdy}, 32'd1);
    @(posedge clk);
    #1;
    send_pkt(2'd1, 2'd1, 3'd2, {6'h00, 6'h00, 6'h22, 6'h11}, 3, {40'h0, 8'hE2, 8'h91, 8'h45});
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
